// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
// UART_PROG_PARITY_EN adds the RX_PARITY state for even-parity frames.
package uart_prog_pkg;

  localparam int          DATA_BITS      = 8;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] END_WORD_DEF   = 32'hFFFF_FFFF;

`ifdef UART_PROG_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  typedef enum logic [1:0] {LD_OFF, LD_RECV, LD_WRITE, LD_DONE} ld_state_t;

endpackage

// File: rtl/uart_prog_if.sv
// Instruction-memory write port driven by the program loader.
interface uart_prog_if #(
  parameter int ADDR_W = 12
) ();
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;

  modport master (output mem_we_o, mem_addr_o, mem_wdata_o);
  modport slave  (input  mem_we_o, mem_addr_o, mem_wdata_o);
endinterface

// File: rtl/uart_prog_rx.sv
// UART byte receiver: two-flop synchronizer, mid-bit sampling, LSB-first 8-bit frames.
// UART_PROG_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_prog_rx
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       rx_i,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic             r_meta, r_sync, r_prev;
  rx_state_t        r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             w_tick, w_fall, w_par_ok, w_stop_ok, w_stop_bad;

  // Synchronizer and previous-value flop idle high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rx_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign w_fall = r_prev & ~r_sync;
  assign w_tick = (r_state == RX_START) ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_tick) w_next = r_sync ? RX_IDLE : RX_DATA;
`ifdef UART_PROG_PARITY_EN
      RX_DATA:   if (w_tick && r_bit == LAST_BIT) w_next = RX_PARITY;
      RX_PARITY: if (w_tick) w_next = RX_STOP;
`else
      RX_DATA:  if (w_tick && r_bit == LAST_BIT) w_next = RX_STOP;
`endif
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    if (r_state == RX_STOP && w_tick) begin
      if (r_sync && w_par_ok) w_stop_ok  = 1'b1;
      else                    w_stop_bad = 1'b1;
    end
  end

`ifdef UART_PROG_PARITY_EN
  logic r_par_ok;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                              r_par_ok <= 1'b1;
    else if (r_state == RX_PARITY && w_tick) r_par_ok <= ((^r_shift) == r_sync);
  end

  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= w_stop_ok;
      rx_err   <= w_stop_bad;
      if (w_stop_ok) rx_byte <= r_shift;
      if (r_state == RX_IDLE || w_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_START) r_bit <= '0;
      if (r_state == RX_DATA && w_tick) begin
        r_shift <= {r_sync, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial firmware loader: assembles little-endian words from UART bytes and writes
// them sequentially to instruction memory, holding the core in reset until the end word.
// UART_PROG_PARITY_EN (in uart_prog_rx) enables even-parity framing.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] END_WORD     = END_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        en_i,
  input  logic        rx_i,
  output logic        ready_o,
  output logic        core_rst_l_o,
  output logic        done_o,
  output logic        err_o,
  uart_prog_if.master mem
);

  localparam int               BCNT_W    = $clog2(BYTES_PER_WORD);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  ld_state_t         r_state, w_next;
  logic              w_rx_valid, w_rx_err;
  logic [7:0]        w_rx_byte;
  logic [BCNT_W-1:0] r_bcnt;
  logic [31:0]       r_word, w_word;
  logic [ADDR_W-1:0] r_idx, r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_full, r_err;
  logic              w_byte_ok, w_last, w_is_end, w_we;

  uart_prog_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_l    (rst_l),
    .rx_i     (rx_i),
    .rx_valid (w_rx_valid),
    .rx_byte  (w_rx_byte),
    .rx_err   (w_rx_err)
  );

  // A byte landing in the same cycle en_i drops is discarded
  assign w_byte_ok = w_rx_valid && (r_state == LD_RECV) && en_i;
  assign w_last    = w_byte_ok && (r_bcnt == LAST_BYTE);
  assign w_word    = {w_rx_byte, r_word[23:0]};
  assign w_is_end  = (w_word == END_WORD);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= LD_OFF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_OFF:   if (en_i) w_next = LD_RECV;
      LD_RECV: begin
        if (!en_i)                      w_next = LD_OFF;
        else if (w_last && w_is_end)    w_next = LD_DONE;
        else if (w_last && !r_full)     w_next = LD_WRITE;
      end
      LD_WRITE: w_next = en_i ? LD_RECV : LD_OFF;
      LD_DONE:  w_next = LD_DONE;
      default:  w_next = LD_OFF;
    endcase
  end

  always_comb begin
    ready_o      = 1'b0;
    w_we         = 1'b0;
    done_o       = 1'b0;
    core_rst_l_o = 1'b0;
    case (r_state)
      LD_RECV:  ready_o = 1'b1;
      LD_WRITE: begin
        ready_o = 1'b1;
        w_we    = 1'b1;
      end
      LD_DONE: begin
        done_o       = 1'b1;
        core_rst_l_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Write address/data are captured with the 4th byte and held until the next write
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_bcnt      <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_full      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      if ((w_rx_err && r_state != LD_DONE) || (w_last && !w_is_end && r_full))
        r_err <= 1'b1;
      case (r_state)
        LD_RECV: begin
          if (!en_i) begin
            r_bcnt <= '0;
            r_word <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
          end else if (w_byte_ok) begin
            if (w_last) begin
              r_bcnt <= '0;
              r_word <= '0;
              if (!w_is_end && !r_full) begin
                r_mem_addr  <= r_idx;
                r_mem_wdata <= w_word;
              end
            end else begin
              r_word[{r_bcnt, 3'b000} +: 8] <= w_rx_byte;
              r_bcnt                        <= r_bcnt + 1'b1;
            end
          end
        end
        LD_WRITE: begin
          if (!en_i) begin
            r_bcnt <= '0;
            r_word <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == '1) r_full <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_we_o    = w_we;
  assign mem.mem_addr_o  = r_mem_addr;
  assign mem.mem_wdata_o = r_mem_wdata;
  assign err_o           = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed + randomized bench for uart_prog_loader with a word-level reference model.
// Honors UART_PROG_PARITY_EN for frame generation and the parity-error step.
module tb_uart_prog_loader;
  import uart_prog_pkg::*;

  localparam int CPB   = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  logic en_i = 1'b0;
  logic rx_i = 1'b1;
  logic ready_o, core_rst_l_o, done_o, err_o;

  uart_prog_if #(.ADDR_W(AW)) mem_if ();

  uart_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .en_i         (en_i),
    .rx_i         (rx_i),
    .ready_o      (ready_o),
    .core_rst_l_o (core_rst_l_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int last_valid = -10;
  int rx_pulses  = 0;
  logic [AW+31:0] obs_q[$];
  logic [AW+31:0] exp_q[$];
  logic [7:0]     m_bytes[$];
  int m_cnt;
  bit m_err, m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (dut.u_rx.rx_valid === 1'b1) begin
      rx_pulses++;
      last_valid = cycle;
    end
    if (mem_if.mem_we_o === 1'b1) begin
      obs_q.push_back({mem_if.mem_addr_o, mem_if.mem_wdata_o});
      check("we_latency", cycle, last_valid + 1);
    end
  end

  // Reference model: bytes -> little-endian words -> sequential writes
  task automatic model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_cnt  = 0;
    m_err  = 0;
    m_done = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [31:0] word;
    if (m_done) return;
    if (!good) begin
      m_err = 1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (word == 32'hFFFF_FFFF) m_done = 1;
      else if (m_cnt < DEPTH) begin
        exp_q.push_back({AW'(m_cnt), word});
        m_cnt++;
      end else m_err = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PROG_PARITY_EN
    rx_i = (^b) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    rx_i = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    model_byte(b, !bad_stop && !bad_par);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0, 1'b0);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready_o, 0);
    check({tag, "_we"}, mem_if.mem_we_o, 0);
    check({tag, "_addr"}, mem_if.mem_addr_o, 0);
    check({tag, "_wdata"}, mem_if.mem_wdata_o, 0);
    check({tag, "_corerst"}, core_rst_l_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  task automatic reset_enable();
    @(negedge clk);
    rst_l = 1'b0;
    en_i  = 1'b0;
    rx_i  = 1'b1;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    model_reset();
    obs_q.delete();
    rx_pulses  = 0;
    last_valid = -10;
    @(negedge clk);
    en_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    bit          bs;

    // Reset and enable
    #1 rst_l = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst_l = 1'b1;
    @(negedge clk);
    en_i = 1'b1;
    check("ready_before", ready_o, 0);
    @(negedge clk);
    check("ready_after", ready_o, 1);
    check("corerst_recv", core_rst_l_o, 0);
    check("we_idle", mem_if.mem_we_o, 0);

    // Single word
    send_word(32'h0000_0013);
    compare_writes("w13");
    check("err_w13", err_o, 0);

    // Two words then terminator
    reset_enable();
    send_word(32'h0000_0093);
    send_word(32'h0010_0113);
    send_word(32'hFFFF_FFFF);
    compare_writes("prog");
    check("done_prog", done_o, 1);
    check("corerst_prog", core_rst_l_o, 1);
    check("ready_prog", ready_o, 0);
    send_byte(8'h55, 1'b0, 1'b0);
    check("done_hold", done_o, 1);
    check("err_done", err_o, 0);
    compare_writes("after_done");

    // Framing error on the second byte
    reset_enable();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    compare_writes("frame");
    check("err_frame", err_o, m_err);
    check("err_frame_set", err_o, 1);

    // Short glitch is not a start bit
    reset_enable();
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("glitch_pulses", rx_pulses, 0);
    check("glitch_err", err_o, 0);
`ifdef UART_PROG_PARITY_EN
    send_byte(8'h01, 1'b0, 1'b1);
    check("par_err", err_o, 1);
    check("par_pulses", rx_pulses, 0);
    compare_writes("par");
`endif

    // Reset in the middle of a word and a frame
    reset_enable();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_l = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    model_reset();
    obs_q.delete();
    @(negedge clk);
    en_i = 1'b1;
    @(negedge clk);
    send_word(32'hDDCC_BBAA);
    compare_writes("after_rst");

    // Enable dropped mid-word clears index and partial word
    reset_enable();
    send_word(32'h1234_5678);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    en_i = 1'b0;
    m_bytes.delete();
    m_cnt = 0;
    repeat (2) @(negedge clk);
    check("ready_off", ready_o, 0);
    check("corerst_off", core_rst_l_o, 0);
    en_i = 1'b1;
    repeat (2) @(negedge clk);
    send_word(32'hCAFE_F00D);
    compare_writes("en_drop");

    // Random words with occasional framing errors, overflowing the memory
    reset_enable();
    for (int i = 0; i < 7; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        bs = ($urandom_range(0, 7) == 0);
        send_byte(w[8*k +: 8], bs, 1'b0);
      end
    end
    send_word(32'hFFFF_FFFF);
    compare_writes("rand");
    check("rand_err", err_o, m_err);
    check("rand_done", done_o, m_done);
    check("rand_corerst", core_rst_l_o, m_done);
    check("rand_ready", ready_o, !m_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
